// File: rtl/cache_pkg.sv
// Shared constants, adaptor state encoding and address helper for the L2-side
// cacheline adaptor; reused by the L2 controller and its bench.
package cache_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int TAG_W   = 27;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int CNT_W   = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_e;

  // Lines are aligned, so the byte offset below the tag is always zero.
  function automatic logic [ADDR_W-1:0] tag_to_addr(input logic [TAG_W-1:0] tag);
    return {tag, {(ADDR_W-TAG_W){1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges single-line arbiter requests to BEATS-long bursts on the physical
// memory bus: reads assemble a line, writes split one lowest beat first.
//
//  state | meaning
//  IDLE  | waiting for read_i/write_i; write wins if both are high
//  RD    | pmem_read held, one beat stored per pmem_resp
//  WR    | pmem_write held, next beat presented after each pmem_resp
//  DONE  | one-cycle resp_o, beat counter cleared, requests ignored
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  adaptor_state_e     r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_W-1:0]  r_buf;
  logic [LINE_W-1:0]  r_line;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_wdata;
  logic               r_resp;
  logic               r_pread;
  logic               r_pwrite;

  logic               w_last;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LINE_W-1:0]  w_buf_rd;

  assign w_last    = (r_cnt == CNT_W'(BEATS-1));
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // Buffer with the incoming beat merged in, so the last beat can go straight to line_o.
  always_comb begin
    w_buf_rd = r_buf;
    w_buf_rd[r_cnt*BURST_W +: BURST_W] = pmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_line   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_resp   <= 1'b0;
      r_pread  <= 1'b0;
      r_pwrite <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (write_i) begin
            r_state  <= WR;
            r_pwrite <= 1'b1;
            r_buf    <= line_i;
            r_wdata  <= line_i[BURST_W-1:0];
            r_addr   <= tag_to_addr(tag_i);
            r_cnt    <= '0;
          end else if (read_i) begin
            r_state <= RD;
            r_pread <= 1'b1;
            r_addr  <= tag_to_addr(tag_i);
            r_cnt   <= '0;
          end
        end
        RD: begin
          if (pmem_resp) begin
            r_buf <= w_buf_rd;
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_line  <= w_buf_rd;
              r_pread <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WR: begin
          if (pmem_resp) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_pwrite <= 1'b0;
              r_resp   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_wdata <= r_buf[w_cnt_nxt*BURST_W +: BURST_W];
            end
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign line_o     = r_line;
  assign resp_o     = r_resp;
  assign pmem_addr  = r_addr;
  assign pmem_read  = r_pread;
  assign pmem_write = r_pwrite;
  assign pmem_wdata = r_wdata;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a transaction-level model checked
// every cycle, plus literal expectations for addresses, beat order and latency.
module tb_cacheline_adaptor;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [TAG_W-1:0]   tag_i = '0;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic [LINE_W-1:0]  line_i = '0;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  pmem_addr;
  logic               pmem_read;
  logic               pmem_write;
  logic [BURST_W-1:0] pmem_wdata;
  logic [BURST_W-1:0] pmem_rdata = '0;
  logic               pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk        (clk),
    .rst        (rst),
    .tag_i      (tag_i),
    .read_i     (read_i),
    .write_i    (write_i),
    .line_i     (line_i),
    .line_o     (line_o),
    .resp_o     (resp_o),
    .pmem_addr  (pmem_addr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  int n_checks    = 0;
  int n_errors    = 0;
  int cyc         = 0;
  int resp_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a line request becomes BEATS acknowledged beats, then one resp cycle.
  bit                 m_ok   = 1'b0;
  bit                 m_rd   = 1'b0;
  bit                 m_wr   = 1'b0;
  bit                 m_done = 1'b0;
  int                 m_idx  = 0;
  logic [BURST_W-1:0] m_beats [BEATS];
  logic [LINE_W-1:0]  m_line = '0;
  logic [ADDR_W-1:0]  m_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_done = 1'b0;
      m_idx = 0; m_line = '0; m_addr = '0;
    end else if (m_ok) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_rd || m_wr) begin
        if (pmem_resp) begin
          if (m_rd) m_beats[m_idx] = pmem_rdata;
          m_idx = m_idx + 1;
          if (m_idx == BEATS) begin
            if (m_rd)
              for (int i = 0; i < BEATS; i++) m_line[i*BURST_W +: BURST_W] = m_beats[i];
            m_rd = 1'b0; m_wr = 1'b0; m_done = 1'b1;
          end
        end
      end else if (write_i) begin
        m_wr = 1'b1; m_idx = 0;
        m_addr = {tag_i, {(ADDR_W-TAG_W){1'b0}}};
        for (int i = 0; i < BEATS; i++) m_beats[i] = line_i[i*BURST_W +: BURST_W];
      end else if (read_i) begin
        m_rd = 1'b1; m_idx = 0;
        m_addr = {tag_i, {(ADDR_W-TAG_W){1'b0}}};
      end
    end
  end

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // One cycle: advance past the edge, then check every output against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_ok) begin
      chk("resp_o",     LINE_W'(resp_o),     LINE_W'(m_done));
      chk("pmem_read",  LINE_W'(pmem_read),  LINE_W'(m_rd));
      chk("pmem_write", LINE_W'(pmem_write), LINE_W'(m_wr));
      chk("line_o",     line_o,              m_line);
      if (m_rd || m_wr) chk("pmem_addr", LINE_W'(pmem_addr), LINE_W'(m_addr));
      if (m_wr) chk("pmem_wdata", LINE_W'(pmem_wdata), LINE_W'(m_beats[m_idx]));
      if (resp_o) resp_pulses++;
    end
  endtask

  task automatic do_read(input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] ln,
                         input int gap, input int abort_after, input bit hold_req,
                         output int lat, output logic [ADDR_W-1:0] addr_seen);
    int t0;
    int n;
    lat = -1;
    addr_seen = '0;
    tag_i = tag;
    read_i = 1'b1;
    t0 = cyc;
    n = 0;
    while (!pmem_read && n < 20) begin tick(); n++; end
    if (!pmem_read) begin
      timeout("read_launch");
      read_i = 1'b0;
      return;
    end
    addr_seen = pmem_addr;
    for (int i = 0; i < BEATS; i++) begin
      if (i > 0) begin
        pmem_resp = 1'b0;
        repeat (gap) tick();
      end
      pmem_rdata = ln[i*BURST_W +: BURST_W];
      pmem_resp = 1'b1;
      tick();
      if (i + 1 == abort_after) begin
        pmem_resp = 1'b0;
        read_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("abort_pmem_read", LINE_W'(pmem_read), LINE_W'(1'b0));
        chk("abort_resp_o", LINE_W'(resp_o), LINE_W'(1'b0));
        rst = 1'b0;
        return;
      end
    end
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    n = 0;
    while (!resp_o && n < 50) begin tick(); n++; end
    if (!resp_o) begin
      timeout("read_resp");
    end else begin
      lat = cyc - t0;
    end
    if (hold_req) tick();
    read_i = 1'b0;
  endtask

  task automatic do_write(input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] ln,
                          input bit also_read, output logic [LINE_W-1:0] seen);
    int n;
    seen = '0;
    tag_i = tag;
    line_i = ln;
    write_i = 1'b1;
    read_i = also_read;
    n = 0;
    while (!pmem_write && n < 20) begin tick(); n++; end
    if (!pmem_write) begin
      timeout("write_launch");
      write_i = 1'b0;
      read_i = 1'b0;
      return;
    end
    for (int i = 0; i < BEATS; i++) begin
      seen[i*BURST_W +: BURST_W] = pmem_wdata;
      pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0;
    n = 0;
    while (!resp_o && n < 50) begin tick(); n++; end
    if (!resp_o) timeout("write_resp");
    write_i = 1'b0;
    read_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] seen;
    logic [LINE_W-1:0] ln1, lnw, ln4, ln5;
    ln1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    lnw = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    ln4 = {64'h0404040404040404, 64'h0303030303030303, 64'h0202020202020202, 64'h0101010101010101};
    ln5 = {64'hF00DF00DF00DF00D, 64'hCAFEBABECAFEBABE, 64'h0123456789ABCDEF, 64'hDEADBEEF00C0FFEE};

    repeat (2) tick();
    chk("rst_line_o",     line_o,                  '0);
    chk("rst_pmem_addr",  LINE_W'(pmem_addr),      '0);
    chk("rst_pmem_wdata", LINE_W'(pmem_wdata),     '0);
    chk("rst_strobes",    LINE_W'({resp_o, pmem_read, pmem_write}), '0);
    rst = 1'b0;
    tick();

    // 1: back-to-back read
    do_read(27'h0ABCDEF, ln1, 0, 0, 1'b0, lat, addr);
    chk("t1_addr", LINE_W'(addr), LINE_W'(32'h1579BDE0));
    chk("t1_line", line_o, {64'h4444444444444444, 64'h3333333333333333,
                            64'h2222222222222222, 64'h1111111111111111});
    chk("t1_latency", LINE_W'(lat), LINE_W'(5));
    repeat (2) tick();

    // 2: write, beats leave lowest first, line_o untouched
    do_write(27'h1234567, lnw, 1'b0, seen);
    chk("t2_beat_order", seen, {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA});
    repeat (2) tick();
    chk("t2_line_kept", line_o, ln1);

    // 3: read with 3-cycle stalls between beats
    do_read(27'h7FFFFFF, ln1, 3, 0, 1'b0, lat, addr);
    chk("t3_addr", LINE_W'(addr), LINE_W'(32'hFFFFFFE0));
    chk("t3_latency", LINE_W'(lat), LINE_W'(14));
    chk("t3_line", line_o, ln1);
    repeat (2) tick();

    // 4: read and write together, write wins
    do_write(27'h0000001, ln4, 1'b1, seen);
    chk("t4_beats", seen, ln4);
    chk("t4_line_kept", line_o, ln1);
    repeat (2) tick();

    // 5: reset after the second read beat, then a clean read
    do_read(27'h0055AA5, ln4, 0, 2, 1'b0, lat, addr);
    tick();
    chk("t5_line_cleared", line_o, '0);
    chk("t5_no_resp", LINE_W'(resp_pulses), LINE_W'(4));
    do_read(27'h0055AA5, ln5, 1, 0, 1'b0, lat, addr);
    chk("t5_line", line_o, ln5);
    chk("t5_latency", LINE_W'(lat), LINE_W'(8));
    repeat (2) tick();

    // 6: stray pmem_resp in IDLE, then read_i held through DONE
    pmem_rdata = 64'h5A5A5A5A5A5A5A5A;
    pmem_resp = 1'b1;
    repeat (3) tick();
    pmem_resp = 1'b0;
    tick();
    chk("t6_idle_line", line_o, ln5);
    do_read(27'h0000100, ln4, 0, 0, 1'b1, lat, addr);
    repeat (4) tick();
    chk("t6_line", line_o, ln4);
    chk("t6_resp_count", LINE_W'(resp_pulses), LINE_W'(6));
    chk("t6_idle_strobes", LINE_W'({pmem_read, pmem_write}), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
